data_mem_responder: RTL

Memory-side responder for the pipelined MIPS core's data port: it receives the core's Memory-stage load/store requests (address, write data, write strobe, read strobe) and serves them from an internal word-addressed RAM after a programmable number of wait states. A ready/stall handshake lets the core's hazard logic freeze the pipeline while an access is in flight. Misaligned and out-of-range accesses are reported instead of touching the array. The block sits between the core top and the memory map, in place of a zero-latency combinational data memory.

---
 rtl/data_mem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-port responder for the pipelined MIPS core: serves load/store requests
// from a word-addressed RAM after WAIT_CYCLES wait states, with stall/ready handshake.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        addr_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic            fault_q, fault_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];

    // Misaligned, or word index beyond the array (upper address bits nonzero).
    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = mem_addr[AW+1:2];
                    wdata_d = mem_wdata;
                    wr_d    = mem_write;
                    fault_d = is_fault(mem_addr);
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response data is captured on the edge entering RESP, before any write lands.
        if (state_d == ST_RESP) begin
            ready_d = 1'b1;
            err_d   = fault_d;
            rdata_d = fault_d ? 32'd0 : mem[addr_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; reset forces IDLE, which blocks a pending write.
    always_ff @(posedge clk) begin
        if (state_q == ST_RESP && wr_q && !fault_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign addr_err  = err_q;
    assign mem_stall = (mem_read | mem_write) & ~ready_q;

endmodule
